// File: rtl/mem_wb_elastic.sv
// MEM/WB pipeline boundary with valid/ready handshake and a 2-entry skid buffer.
// Adds a synchronous bubble-inserting flush and a saturating back-pressure counter.
module mem_wb_elastic #(
  parameter int unsigned             XLEN        = 32,
  parameter int unsigned             WA_W        = 5,
  parameter int unsigned             CTRL_W      = 3,
  parameter logic [CTRL_W-1:0]       BUBBLE_CTRL = '0,
  parameter int unsigned             CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   rd_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [WA_W-1:0]   wa_in,
  input  logic [XLEN-1:0]   instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [XLEN-1:0]   rd_out,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [WA_W-1:0]   wa_out,
  output logic [XLEN-1:0]   instr_out,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned PW = CTRL_W + 3 * XLEN + WA_W;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PW-1:0]     in_pl;
  logic [CTRL_W-1:0] head_ctrl;
  logic              acc, deq, stall;

  assign in_pl = {ctrl_in, rd_in, alu_result_in, wa_in, instr_in};
  assign {head_ctrl, rd_out, alu_result_out, wa_out, instr_out} = head_q;

  // Handshake flags decode straight from the state flop: no input-to-output comb path.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign ctrl_out  = out_valid ? head_ctrl : BUBBLE_CTRL;
  assign stall_cnt = stall_cnt_q;

  assign acc   = in_valid & in_ready;
  assign deq   = out_valid & out_ready;
  assign stall = out_valid & ~out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            head_d  = in_pl;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            head_d = in_pl;
          end else if (acc) begin
            skid_d  = in_pl;
            state_d = ST_FULL;
          end else if (deq) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deq) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/mem_wb_elastic.md
Name: mem_wb_elastic

Overview:
Parametrised MEM/WB pipeline boundary register, the successor of the fixed 32-bit free-running MEM/WB latch. It carries WB control plus the read-data, ALU-result, write-address and instruction fields under a valid/ready handshake. A 2-entry skid buffer lets the MEM stage stall without a combinational ready path. It adds a synchronous flush that inserts bubbles and a saturating back-pressure counter for performance debug.

Parameters:
XLEN, 32, width of rd, alu_result and instr fields
WA_W, 5, width of destination register address field
CTRL_W, 3, width of WB control bundle (bit0 = RegWrite, bits[2:1] = MemtoReg)
BUBBLE_CTRL, 0, control value driven on bubble, reset or flush (must have RegWrite = 0)
CNT_W, 16, width of back-pressure counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM stage presents a valid payload
in_ready  out  1  block can accept; registered, equals (state != FULL)
ctrl_in  in  CTRL_W  WB control bundle
rd_in  in  XLEN  memory read data
alu_result_in  in  XLEN  ALU result
wa_in  in  WA_W  destination register address
instr_in  in  XLEN  instruction word (debug)
out_valid  out  1  WB payload valid
out_ready  in  1  WB stage consumes payload this cycle
ctrl_out  out  CTRL_W  BUBBLE_CTRL whenever out_valid = 0
rd_out, alu_result_out  out  XLEN  head-entry data
wa_out  out  WA_W  head-entry address
instr_out  out  XLEN  head-entry instruction
flush  in  1  synchronous kill of all held entries
clr_cnt  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- acc = in_valid & in_ready; deq = out_valid & out_ready.
- Storage: head entry (drives outputs) and skid entry. State: EMPTY, ONE (head valid), FULL (head + skid valid).
- EMPTY: acc -> ONE, head <= input.
- ONE: acc & deq -> ONE, head <= input; acc & !deq -> FULL, skid <= input; !acc & deq -> EMPTY; otherwise hold.
- FULL: in_ready = 0, so no accept. deq -> ONE, head <= skid; otherwise hold.
- Latency: accept in cycle N -> out_valid in cycle N+1 from EMPTY. Full throughput of 1/cycle when out_ready stays high. Strict FIFO order; no payload is duplicated or dropped except by flush.
- out_valid = (state != EMPTY). in_ready and out_valid come directly from the state register; there is no combinational in->out path.
- ctrl_out = BUBBLE_CTRL when out_valid = 0. Data outputs then hold their last value (don't care).
- flush: next state EMPTY, both entries invalidated, in_valid that cycle is ignored. flush beats simultaneous acc/deq. in_ready = 1 the following cycle.
- stall_cnt: +1 each cycle out_valid & !out_ready, saturates at 2^CNT_W-1. clr_cnt has priority over increment. Unaffected by flush.
- Reset (rst_n low, any time, including mid-transfer): state EMPTY, out_valid 0, in_ready 1, ctrl_out BUBBLE_CTRL, data outputs 0, stall_cnt 0. Takes effect immediately without waiting for a clock edge.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, alu_result_in=1..8 -> out_valid from cycle 1, alu_result_out=1..8 in order, stall_cnt=0.
- Back-pressure: send A=0x11, B=0x22, out_ready=0 -> state FULL, in_ready=0 after B, stall_cnt increments each cycle. Raise out_ready -> A then B delivered, in_ready back to 1.
- Flush: hold FULL with ctrl_in=3'b001, assert flush with in_valid=1 -> next cycle out_valid=0, ctrl_out=BUBBLE_CTRL (RegWrite=0), in_ready=1, new payload not captured.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with valid head -> stall_cnt stops at 15. clr_cnt pulse -> 0.
- Async reset mid-operation: in FULL, drop rst_n between clock edges -> out_valid=0, in_ready=1, ctrl_out=BUBBLE_CTRL immediately; after release, the first accepted payload appears one cycle later.
- Simultaneous acc & deq in ONE: head is replaced with the new payload, state stays ONE, no skid use, order preserved.
